// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the 16-bit pipeline front end.
// Holds the fetch FSM state type, the fetch/decode record and the fixed opcodes.
package fetch_stage_pkg;

   localparam int unsigned INSTR_W = 16;
   localparam int unsigned ADDR_W  = 16;

   localparam logic [INSTR_W-1:0] NOP_INSTR = 16'hE000;
   localparam logic [3:0]         OP_HLT    = 4'hF;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      SQUASH = 2'd1,
      HALT   = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic [ADDR_W-1:0]  pc;
      logic [INSTR_W-1:0] instr;
   } fd_rec_t;

   localparam fd_rec_t FD_BUBBLE = '{pc: ADDR_W'(0), instr: NOP_INSTR};

   function automatic logic is_hlt(input logic [INSTR_W-1:0] instr);
      return instr[INSTR_W-1 -: 4] == OP_HLT;
   endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry {pc, instr} holding register that catches a fetch accepted
// while decode is stalled.
module fetch_skid_buffer
   import fetch_stage_pkg::*;
(
   input  logic    clk,
   input  logic    rst,
   input  logic    load,
   input  logic    drain,
   input  logic    clear,
   input  fd_rec_t din,
   output logic    valid,
   output fd_rec_t dout
);

   // clear (redirect) wins over a same-cycle load
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid <= 1'b0;
         dout  <= FD_BUBBLE;
      end else if (clear) begin
         valid <= 1'b0;
      end else if (load) begin
         valid <= 1'b1;
         dout  <= din;
      end else if (drain) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, talks to a variable-latency imem and
// drives the fetch/decode register, with skid, redirect squash and halt.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [15:0] RESET_PC = 16'h0000
)
(
   input  logic                clk,
   input  logic                rst,
   input  logic                stall,
   input  logic                branch_taken,
   input  logic [ADDR_W-1:0]   branch_pc,
   output logic                imem_req,
   output logic [ADDR_W-1:0]   imem_addr,
   input  logic                imem_ready,
   input  logic [INSTR_W-1:0]  imem_rdata,
   output logic [ADDR_W-1:0]   curr_pc_fd,
   output logic [INSTR_W-1:0]  curr_instr_fd,
   output logic                halted
);

   localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(2);

   fetch_state_t      state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] redir_q, redir_d;
   fd_rec_t           fd_q, fd_d;
   logic              req_q, req_d;
   logic              halted_q, halted_d;

   logic    redirect;
   logic    accept;
   logic    skid_load, skid_drain, skid_clear;
   logic    skid_valid, skid_valid_d;
   fd_rec_t skid_dout;

   assign redirect = branch_taken & ~stall;
   assign accept   = (state_q == RUN) & req_q & imem_ready & ~redirect;

   fetch_skid_buffer u_skid (
      .clk   (clk),
      .rst   (rst),
      .load  (skid_load),
      .drain (skid_drain),
      .clear (skid_clear),
      .din   ('{pc: pc_q, instr: imem_rdata}),
      .valid (skid_valid),
      .dout  (skid_dout)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= RUN;
         pc_q     <= RESET_PC;
         redir_q  <= RESET_PC;
         fd_q     <= FD_BUBBLE;
         req_q    <= 1'b1;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         redir_q  <= redir_d;
         fd_q     <= fd_d;
         req_q    <= req_d;
         halted_q <= halted_d;
      end
   end

   // next state, PC and FD contents; priority redirect > stall > normal
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      redir_d    = redir_q;
      fd_d       = fd_q;
      skid_load  = 1'b0;
      skid_drain = 1'b0;
      skid_clear = 1'b0;

      if (state_q == SQUASH) begin
         fd_d = FD_BUBBLE;
         if (redirect) redir_d = branch_pc;
         if (imem_ready) begin
            pc_d    = redirect ? branch_pc : redir_q;
            state_d = RUN;
         end
      end else if (redirect) begin
         fd_d       = FD_BUBBLE;
         skid_clear = 1'b1;
         // an access still in flight must finish before the target is issued
         if (imem_ready || !req_q) begin
            pc_d    = branch_pc;
            state_d = RUN;
         end else begin
            redir_d = branch_pc;
            state_d = SQUASH;
         end
      end else if (stall) begin
         if (accept) begin
            skid_load = 1'b1;
            pc_d      = pc_q + PC_STEP;
            if (is_hlt(imem_rdata)) state_d = HALT;
         end
      end else if (skid_valid) begin
         fd_d       = skid_dout;
         skid_drain = 1'b1;
      end else if (accept) begin
         fd_d = '{pc: pc_q, instr: imem_rdata};
         pc_d = pc_q + PC_STEP;
         if (is_hlt(imem_rdata)) state_d = HALT;
      end else begin
         fd_d = FD_BUBBLE;
      end

      if (skid_clear)      skid_valid_d = 1'b0;
      else if (skid_load)  skid_valid_d = 1'b1;
      else if (skid_drain) skid_valid_d = 1'b0;
      else                 skid_valid_d = skid_valid;

      req_d    = ((state_d == RUN) && !skid_valid_d) || (state_d == SQUASH);
      halted_d = (state_d == HALT);
   end

   assign imem_req      = req_q;
   assign imem_addr     = pc_q;
   assign curr_pc_fd    = fd_q.pc;
   assign curr_instr_fd = fd_q.instr;
   assign halted        = halted_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios then randomized traffic, every cycle
// compared against a behavioural model of the fetch stage and memory.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        branch_taken;
   logic [15:0] branch_pc;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_ready;
   logic [15:0] imem_rdata;
   logic [15:0] curr_pc_fd;
   logic [15:0] curr_instr_fd;
   logic        halted;

   fetch_stage #(.RESET_PC(16'h0000)) dut (
      .clk           (clk),
      .rst           (rst),
      .stall         (stall),
      .branch_taken  (branch_taken),
      .branch_pc     (branch_pc),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_ready    (imem_ready),
      .imem_rdata    (imem_rdata),
      .curr_pc_fd    (curr_pc_fd),
      .curr_instr_fd (curr_instr_fd),
      .halted        (halted)
   );

   always #5 clk = ~clk;

   int n_chk = 0, n_pass = 0, n_fail = 0;

   // reference model: 0 = fetching, 1 = discarding an in-flight access, 2 = stopped
   int          m_mode;
   logic [15:0] m_pc, m_tgt, m_fd_pc, m_fd_ins;
   logic [31:0] m_skid[$];

   // memory model
   bit          mem_pend;
   int          mem_wait;
   bit          rand_lat, hlt_on, rand_hlt;
   logic [15:0] miss_addr, hlt_addr;
   int          miss_lat;

   function automatic logic m_req();
      return (m_mode == 0 && m_skid.size() == 0) || m_mode == 1;
   endfunction

   function automatic logic [15:0] mem_word(input logic [15:0] a);
      if ((hlt_on && a == hlt_addr) || (rand_hlt && a[6:1] == 6'h2A)) return 16'hF000;
      return {4'h1, a[11:0]};
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("imem_req", {15'b0, imem_req}, {15'b0, m_req()});
      chk("imem_addr", imem_addr, m_pc);
      chk("curr_pc_fd", curr_pc_fd, m_fd_pc);
      chk("curr_instr_fd", curr_instr_fd, m_fd_ins);
      chk("halted", {15'b0, halted}, (m_mode == 2) ? 16'd1 : 16'd0);
   endtask

   task automatic model_reset();
      m_mode   = 0;
      m_pc     = 16'h0000;
      m_tgt    = 16'h0000;
      m_fd_pc  = 16'h0000;
      m_fd_ins = 16'hE000;
      m_skid.delete();
      mem_pend = 1'b0;
      mem_wait = 0;
   endtask

   task automatic deliver(input logic [15:0] d, input bit to_skid);
      if (to_skid) m_skid.push_back({m_pc, d});
      else begin
         m_fd_pc  = m_pc;
         m_fd_ins = d;
      end
      m_pc = m_pc + 16'd2;
      if (d[15:12] == 4'hF) m_mode = 2;
   endtask

   task automatic model_step(input logic s, input logic bt, input logic [15:0] bpc,
                             input logic rdy, input logic [15:0] d, input logic rq);
      logic redir, got;
      logic [31:0] e;
      redir = bt && !s;
      got   = (m_mode == 0) && rq && rdy && !redir;
      if (m_mode == 1) begin
         m_fd_pc  = 16'h0000;
         m_fd_ins = 16'hE000;
         if (redir) m_tgt = bpc;
         if (rdy) begin
            m_pc   = m_tgt;
            m_mode = 0;
         end
      end else if (redir) begin
         m_fd_pc  = 16'h0000;
         m_fd_ins = 16'hE000;
         m_skid.delete();
         if (m_mode == 2 || rdy || !rq) begin
            m_pc   = bpc;
            m_mode = 0;
         end else begin
            m_tgt  = bpc;
            m_mode = 1;
         end
      end else if (s) begin
         if (got) deliver(d, 1'b1);
      end else if (m_skid.size() != 0) begin
         e        = m_skid.pop_front();
         m_fd_pc  = e[31:16];
         m_fd_ins = e[15:0];
      end else if (got) begin
         deliver(d, 1'b0);
      end else begin
         m_fd_pc  = 16'h0000;
         m_fd_ins = 16'hE000;
      end
   endtask

   // one clock: drive inputs, advance model at the edge, compare just after
   task automatic cycle(input logic s, input logic bt, input logic [15:0] bpc);
      logic rq, rdy;
      logic [15:0] d;
      rq = m_req();
      if (rq && !mem_pend) begin
         mem_pend = 1'b1;
         mem_wait = rand_lat ? int'($urandom_range(0, 3)) : ((m_pc == miss_addr) ? miss_lat : 0);
      end
      rdy = rq && mem_pend && (mem_wait == 0);
      d   = rdy ? mem_word(m_pc) : 16'hDEAD;
      stall        = s;
      branch_taken = bt;
      branch_pc    = bpc;
      imem_ready   = rdy;
      imem_rdata   = d;
      @(posedge clk);
      model_step(s, bt, bpc, rdy, d, rq);
      if (rdy) mem_pend = 1'b0;
      else if (mem_pend) mem_wait--;
      #1;
      check_all();
   endtask

   task automatic do_reset();
      stall        = 1'b0;
      branch_taken = 1'b0;
      branch_pc    = 16'h0000;
      imem_ready   = 1'b0;
      imem_rdata   = 16'h0000;
      rst          = 1'b0;
      #2;
      model_reset();
      check_all();
      @(posedge clk);
      #1;
      check_all();
      rst = 1'b1;
   endtask

   initial begin
      rand_lat  = 1'b0;
      hlt_on    = 1'b0;
      rand_hlt  = 1'b0;
      hlt_addr  = 16'h0008;
      miss_addr = 16'h0004;
      miss_lat  = 3;
      rst       = 1'b1;
      #3;
      do_reset();
      chk("rst_instr", curr_instr_fd, 16'hE000);

      // streaming hits, then a 3-cycle miss at 0x0004
      cycle(0, 0, 0);
      chk("hit0_pc", curr_pc_fd, 16'h0000);
      chk("hit0_instr", curr_instr_fd, 16'h1000);
      cycle(0, 0, 0);
      chk("hit1_instr", curr_instr_fd, 16'h1002);
      for (int i = 0; i < 3; i++) begin
         cycle(0, 0, 0);
         chk("miss_bubble", curr_instr_fd, 16'hE000);
         chk("miss_addr_held", imem_addr, 16'h0004);
      end
      cycle(0, 0, 0);
      chk("miss_done", curr_instr_fd, 16'h1004);

      // stall catches the hit at 0x0006 in the skid
      for (int i = 0; i < 4; i++) begin
         cycle(1, 0, 0);
         chk("stall_fd_hold", curr_pc_fd, 16'h0004);
         chk("stall_req_low", {15'b0, imem_req}, 16'd0);
      end
      cycle(0, 0, 0);
      chk("skid_drain_pc", curr_pc_fd, 16'h0006);
      chk("skid_next_addr", imem_addr, 16'h0008);

      // hlt at 0x0008
      hlt_on = 1'b1;
      cycle(0, 0, 0);
      chk("hlt_instr", curr_instr_fd, 16'hF000);
      chk("hlt_halted", {15'b0, halted}, 16'd1);
      for (int i = 0; i < 2; i++) cycle(0, 0, 0);
      cycle(1, 1, 16'h0030);
      chk("hlt_stall_branch_ignored", {15'b0, halted}, 16'd1);
      cycle(0, 1, 16'h0020);
      chk("hlt_redirect_clear", {15'b0, halted}, 16'd0);
      chk("hlt_redirect_addr", imem_addr, 16'h0020);
      hlt_on = 1'b0;
      cycle(0, 0, 0);
      chk("resume_pc", curr_pc_fd, 16'h0020);

      // redirect to 0x0040 during a miss at 0x0010
      miss_addr = 16'h0010;
      cycle(0, 1, 16'h0010);
      cycle(0, 0, 0);
      cycle(0, 1, 16'h0040);
      chk("squash_addr_held", imem_addr, 16'h0010);
      cycle(0, 0, 0);
      cycle(0, 0, 0);
      chk("squash_next_addr", imem_addr, 16'h0040);
      chk("squash_bubble", curr_instr_fd, 16'hE000);
      cycle(0, 0, 0);
      chk("squash_target_fd", curr_pc_fd, 16'h0040);

      // PC wrap at 0xFFFE
      cycle(0, 1, 16'hFFFC);
      cycle(0, 0, 0);
      cycle(0, 0, 0);
      chk("wrap_fffe", curr_pc_fd, 16'hFFFE);
      chk("wrap_addr", imem_addr, 16'h0000);
      cycle(0, 0, 0);
      chk("wrap_zero_instr", curr_instr_fd, 16'h1000);

      // reset while squashing
      miss_addr = 16'h0100;
      cycle(0, 1, 16'h0100);
      cycle(0, 0, 0);
      cycle(0, 1, 16'h0200);
      do_reset();
      chk("squash_rst_addr", imem_addr, 16'h0000);
      chk("squash_rst_instr", curr_instr_fd, 16'hE000);

      // randomized traffic
      rand_lat = 1'b1;
      rand_hlt = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         logic s, bt;
         logic [15:0] bpc;
         if (i == 1500) do_reset();
         s   = ($urandom_range(0, 3) == 0);
         bt  = ($urandom_range(0, 9) == 0);
         bpc = ($urandom_range(0, 3) != 0) ? {8'h00, 7'($urandom), 1'b0}
                                           : {15'($urandom), 1'b0};
         cycle(s, bt, bpc);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 16-bit five-stage pipeline, directly upstream of the decode stage. Owns the PC, issues requests to a variable-latency instruction memory, and drives the fetch/decode pipeline register (`curr_pc_fd`, `curr_instr_fd`) that decode consumes. Handles decode-side stalls with a one-entry skid buffer, taken-branch redirects (including redirects that arrive while a memory access is outstanding), and halt.

## Interface
Parameters:
- `RESET_PC`, 16'h0000, first fetch address after reset.

Ports:
- `clk`  in  1  Single clock; all state updates on the rising edge.
- `rst`  in  1  Asynchronous, active-low reset.
- `stall`  in  1  Hazard stall from decode. Hold the FD register.
- `branch_taken`  in  1  Decode resolved a taken branch/jump this cycle (decode `flush`).
- `branch_pc`  in  16  Redirect target, valid with `branch_taken`.
- `imem_req`  out  1  Fetch request.
- `imem_addr`  out  16  Fetch byte address. Stable while `imem_req` is high and `imem_ready` is low.
- `imem_ready`  in  1  `imem_rdata` is valid for `imem_addr`. May rise in the request cycle (hit) or later (miss).
- `imem_rdata`  in  16  Fetched instruction.
- `curr_pc_fd`  out  16  Address of the instruction in FD.
- `curr_instr_fd`  out  16  Instruction in FD. NOP 16'hE000 when empty.
- `halted`  out  1  A `hlt` (opcode 4'hF) has been fetched and fetch is stopped.

## Operation
- `redirect = branch_taken & ~stall`. Priority order: reset, redirect, stall, normal.
- FSM states:
  - RUN: fetching.
  - SQUASH: a redirect arrived with an access outstanding. The access must complete, and its data is discarded.
  - HALT: stopped.
- Reset values:
  - `pc_q = RESET_PC`, state RUN, skid empty.
  - `curr_pc_fd = 0`, `curr_instr_fd = 16'hE000`, `halted = 0`.
- `imem_addr = pc_q`.
- `imem_req = 1` in RUN with skid empty, and always in SQUASH. It is 0 in HALT and whenever the skid is full.
- Accept condition: in RUN, `imem_req & imem_ready & ~redirect`.
- RUN accept with `~stall`:
  - FD ← {`pc_q`, `imem_rdata`}.
  - `pc_q` ← `pc_q + 2`, with 16-bit wrap (0xFFFE → 0x0000).
- RUN accept with `stall`:
  - FD holds.
  - skid ← {`pc_q`, `imem_rdata`}.
  - `pc_q` ← `pc_q + 2`.
- RUN, `~stall`, skid full: FD ← skid, skid empties. No request is made that cycle.
- RUN, no accept and `~stall` and skid empty: FD ← bubble (`pc_fd = 0`, instr 16'hE000).
- Redirect in RUN:
  - FD ← bubble, skid cleared.
  - If `imem_ready` is high or no request is outstanding: `pc_q` ← `branch_pc`, stay in RUN.
  - Otherwise: latch `branch_pc` into `redir_q` and go to SQUASH.
- SQUASH:
  - FD ← bubble each cycle.
  - On `imem_ready`: data discarded, `pc_q` ← `redir_q`, go to RUN.
  - A further redirect while in SQUASH overwrites `redir_q`.
- Halt:
  - When an accepted instruction has `[15:12] == 4'hF`, it is delivered to FD/skid normally.
  - Then state → HALT and `halted = 1`.
  - `pc_q` still advances by 2.
- HALT:
  - FD behaves as in RUN (drains the skid, then bubbles).
  - A redirect (wrong-path `hlt`) sets `pc_q` ← `branch_pc`, clears `halted`, and returns to RUN.
  - Otherwise HALT is left only by reset.
- Reset asserted mid-access: all state returns to its reset value immediately. The outstanding memory response is not tracked and is assumed dropped by memory on reset.

## Timing
- Hit latency: request at cycle t with `imem_ready` at t → instruction visible in FD at t+1. Sustained throughput is one instruction per cycle.
- Miss of N cycles: N bubbles enter FD. PC holds and the address is stable.
- Redirect at t: the FD bubble and the new `pc_q` are visible at t+1. First target request at t+1 (RUN) or on the cycle after the squashed access completes (SQUASH).
- Stall release with skid full: the skid instruction is in FD the next cycle, with no bubble. Fetch resumes the cycle after that.
- `halted` rises the cycle after the `hlt` accept.

## Structure
- Shared pipeline package holds:
  - `NOP_INSTR` (16'hE000)
  - `OP_HLT` (4'hF)
  - `fetch_state_t` (RUN, SQUASH, HALT)
  - `INSTR_W` / `ADDR_W` (16)
  - a packed FD-record typedef {pc, instr}
- One sub-module: `fetch_skid_buffer`. It is a one-entry {pc, instr} holding register with `load`, `drain`, `clear` and a `valid` output.

## Test plan
- Reset then always-ready memory returning `addr|16'h1000`: FD sequence {0,1000}, {2,1002}, {4,1004}, one per cycle.
- Miss of 3 cycles at 0x0004: three E000 bubbles, `imem_addr` held at 0x0004, then {4,…}.
- Stall for 4 cycles during a hit at 0x0006: FD holds, 0x0006 is captured in the skid, `imem_req` drops. On release FD gets {6,…} with no bubble and no refetch of 0x0006.
- Redirect to 0x0040 during a 3-cycle miss at 0x0010: FD bubbles, the 0x0010 data is discarded, the next request is 0x0040, and FD gets {0x40,…}.
- Fetch of F000 at 0x0008: `halted = 1`, `imem_req = 0` thereafter. A later redirect to 0x0020 resumes fetch at 0x0020. `branch_taken` together with `stall` is ignored.
- PC at 0xFFFE wraps to 0x0000. Reset asserted during SQUASH returns `pc_q` to `RESET_PC` with FD = E000.
